// File: rtl/pe_output_stage_if.sv
// Byte-write handshake from the PE output stage to the activation memory.
interface pe_output_stage_if #(
    parameter int addr_w = 11,
    parameter int data_w = 8
);
    logic              wr_valid;
    logic              wr_ready;
    logic [addr_w-1:0] wr_addr;
    logic [data_w-1:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/pe_output_stage.sv
// Captures a batch of PE accumulator lanes, applies ReLU / arithmetic shift / byte
// saturation, then streams the bytes to memory at a persistent, wrapping address.
module pe_output_stage #(
    parameter int log_n_add     = 3,
    parameter int log_bit_width = 3,
    parameter int log_rom_size  = 11
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic [(2**log_n_add)*(2**(log_bit_width+1))-1:0]       output_reuse,
    input  logic                                                   end_conv_layer,
    input  logic                                                   relu_en,
    input  logic [log_bit_width:0]                                 shift_amt,
    input  logic                                                   load_out_base,
    input  logic [log_rom_size-1:0]                                out_base_addr,
    pe_output_stage_if.master                                      wr,
    output logic                                                   busy,
    output logic                                                   done,
    output logic                                                   sat_flag,
    output logic                                                   overrun
);
    localparam int n_lanes    = 2**log_n_add;
    localparam int lane_w     = 2**(log_bit_width+1);
    localparam int byte_w     = 2**log_bit_width;
    localparam int byte_max_i = 2**(byte_w-1) - 1;

    localparam logic signed [lane_w-1:0] byte_max = lane_w'(byte_max_i);
    localparam logic signed [lane_w-1:0] byte_min = lane_w'(-byte_max_i - 1);
    localparam logic [log_n_add-1:0]     last_idx = '1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]              state;
    logic [log_n_add-1:0]    idx;
    logic [log_rom_size-1:0] ptr;
    logic [byte_w-1:0]       lane_buf  [n_lanes];
    logic [byte_w-1:0]       proc_byte [n_lanes];
    logic [n_lanes-1:0]      proc_sat;

    // Returns {saturated, byte}.
    function automatic logic [byte_w:0] proc_lane(
        input logic signed [lane_w-1:0] x,
        input logic                     relu,
        input logic [log_bit_width:0]   sh
    );
        logic signed [lane_w-1:0] v;
        v = (relu && (x < 0)) ? '0 : x;
        v = v >>> sh;
        if (v > byte_max)
            return {1'b1, byte_max[byte_w-1:0]};
        else if (v < byte_min)
            return {1'b1, byte_min[byte_w-1:0]};
        else
            return {1'b0, v[byte_w-1:0]};
    endfunction

    always_comb begin
        proc_sat = '0;
        for (int unsigned i = 0; i < n_lanes; i++) begin
            {proc_sat[i], proc_byte[i]} =
                proc_lane(output_reuse[i*lane_w +: lane_w], relu_en, shift_amt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            ptr      <= '0;
            done     <= 1'b0;
            sat_flag <= 1'b0;
            overrun  <= 1'b0;
            for (int unsigned i = 0; i < n_lanes; i++)
                lane_buf[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_out_base) begin
                        ptr      <= out_base_addr;
                        sat_flag <= 1'b0;
                        overrun  <= 1'b0;
                    end
                    // A coincident capture still reports its own saturation after the clear.
                    if (end_conv_layer) begin
                        for (int unsigned i = 0; i < n_lanes; i++)
                            lane_buf[i] <= proc_byte[i];
                        idx   <= '0;
                        state <= DRAIN;
                        if (|proc_sat)
                            sat_flag <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (end_conv_layer)
                        overrun <= 1'b1;
                    if (wr.wr_ready) begin
                        idx <= idx + 1'b1;
                        ptr <= ptr + 1'b1;
                        if (idx == last_idx) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy        = (state == DRAIN);
    assign wr.wr_valid = (state == DRAIN);
    assign wr.wr_addr  = ptr;
    assign wr.wr_data  = (state == DRAIN) ? lane_buf[idx] : '0;
endmodule

// File: tb/tb_pe_output_stage.sv
// Directed bench for pe_output_stage: shaping, saturation, stalls, wrap, overrun, reset.
module tb_pe_output_stage;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] output_reuse;
    logic         end_conv_layer;
    logic         relu_en;
    logic [3:0]   shift_amt;
    logic         load_out_base;
    logic [10:0]  out_base_addr;
    logic         busy, done, sat_flag, overrun;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_b [8];

    // lanes l7..l0 = 0010 0003 FE00 01FC FFFF 0005 FF00 0100
    localparam logic [127:0] LANES_A = {16'h0010, 16'h0003, 16'hFE00, 16'h01FC,
                                        16'hFFFF, 16'h0005, 16'hFF00, 16'h0100};
    localparam logic [127:0] LANES_S = {16'h0000, 16'h0000, 16'h0000, 16'h007F,
                                        16'hFF80, 16'h0080, 16'h8000, 16'h7FFF};

    pe_output_stage_if #(.addr_w(11), .data_w(8)) wr_if ();

    pe_output_stage #(
        .log_n_add    (3),
        .log_bit_width(3),
        .log_rom_size (11)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .output_reuse  (output_reuse),
        .end_conv_layer(end_conv_layer),
        .relu_en       (relu_en),
        .shift_amt     (shift_amt),
        .load_out_base (load_out_base),
        .out_base_addr (out_base_addr),
        .wr            (wr_if),
        .busy          (busy),
        .done          (done),
        .sat_flag      (sat_flag),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_exp(input logic [63:0] v);
        for (int i = 0; i < 8; i++) exp_b[i] = v[8*i +: 8];
    endtask

    // Drives a capture cycle, then scrambles relu_en/shift_amt so the batch must not depend on them.
    task automatic capture(input logic [127:0] lanes, input logic r, input logic [3:0] s,
                           input logic ld, input logic [10:0] base);
        output_reuse   = lanes;
        relu_en        = r;
        shift_amt      = s;
        load_out_base  = ld;
        out_base_addr  = base;
        end_conv_layer = 1'b1;
        @(negedge clk);
        end_conv_layer = 1'b0;
        load_out_base  = 1'b0;
        relu_en        = ~r;
        shift_amt      = s + 4'd5;
    endtask

    task automatic drain(input logic [10:0] base, input bit stall, input int ovr_at, input string tag);
        int k   = 0;
        int cyc = 0;
        logic rdy;
        logic [10:0] a;
        while (k < 8 && cyc < 64) begin
            a = base + 11'(k);
            check({tag, "_valid"}, wr_if.wr_valid, 1);
            check({tag, "_busy"},  busy, 1);
            check({tag, "_done"},  done, 0);
            check({tag, "_addr"},  wr_if.wr_addr, a);
            check({tag, "_data"},  wr_if.wr_data, exp_b[k]);
            end_conv_layer = 1'b0;
            load_out_base  = 1'b0;
            if (cyc == ovr_at) begin
                end_conv_layer = 1'b1;
                output_reuse   = ~output_reuse;
                load_out_base  = 1'b1;
                out_base_addr  = 11'h333;
            end
            rdy = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            wr_if.wr_ready = rdy;
            @(negedge clk);
            if (rdy) k++;
            cyc++;
        end
        end_conv_layer = 1'b0;
        load_out_base  = 1'b0;
        wr_if.wr_ready = 1'b1;
        check({tag, "_accepts"},  k, 8);
        check({tag, "_end_valid"}, wr_if.wr_valid, 0);
        check({tag, "_end_busy"},  busy, 0);
        check({tag, "_end_done"},  done, 1);
    endtask

    initial begin
        rst = 1'b1;
        output_reuse = '0;
        end_conv_layer = 1'b0;
        relu_en = 1'b0;
        shift_amt = '0;
        load_out_base = 1'b0;
        out_base_addr = '0;
        wr_if.wr_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", wr_if.wr_valid, 0);
        check("rst_addr",  wr_if.wr_addr, 0);
        check("rst_data",  wr_if.wr_data, 0);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_sat",   sat_flag, 0);
        check("rst_ovr",   overrun, 0);
        rst = 1'b0;

        load_out_base = 1'b1;
        out_base_addr = 11'h010;
        @(negedge clk);
        load_out_base = 1'b0;
        check("load_addr", wr_if.wr_addr, 11'h010);

        // basic shaping, shift 2
        capture(LANES_A, 1'b0, 4'd2, 1'b0, 11'h000);
        set_exp(64'h04_00_80_7F_FF_01_C0_40);
        drain(11'h010, 1'b0, -1, "A");
        check("A_sat", sat_flag, 0);
        @(negedge clk);
        check("A_done_pulse", done, 0);

        // ReLU; pointer continues from previous batch
        capture(LANES_A, 1'b1, 4'd2, 1'b0, 11'h000);
        set_exp(64'h04_00_00_7F_00_01_00_40);
        drain(11'h018, 1'b0, -1, "B");
        check("B_sat", sat_flag, 0);

        // saturation with stalled sink
        capture(LANES_S, 1'b0, 4'd0, 1'b0, 11'h000);
        set_exp(64'h00_00_00_7F_80_7F_80_7F);
        drain(11'h020, 1'b1, -1, "C");
        check("C_sat", sat_flag, 1);
        @(negedge clk);
        check("C_sat_sticky", sat_flag, 1);
        check("C_ovr", overrun, 0);

        load_out_base = 1'b1;
        out_base_addr = 11'h100;
        @(negedge clk);
        load_out_base = 1'b0;
        check("load_sat_clr", sat_flag, 0);
        check("load_addr2", wr_if.wr_addr, 11'h100);

        // coincident load+capture, address wrap, overrun and load ignored in DRAIN
        capture(LANES_A, 1'b0, 4'd2, 1'b1, 11'h7FE);
        set_exp(64'h04_00_80_7F_FF_01_C0_40);
        drain(11'h7FE, 1'b0, 2, "D");
        check("D_ovr", overrun, 1);
        check("D_sat", sat_flag, 0);
        check("D_next_addr", wr_if.wr_addr, 11'h006);
        @(negedge clk);
        check("D_ovr_sticky", overrun, 1);

        load_out_base = 1'b1;
        out_base_addr = 11'h050;
        @(negedge clk);
        load_out_base = 1'b0;
        check("load_ovr_clr", overrun, 0);

        // reset mid-drain after three accepts
        capture(LANES_A, 1'b0, 4'd2, 1'b0, 11'h000);
        for (int j = 0; j < 3; j++) begin
            check("E_addr", wr_if.wr_addr, 11'h050 + 11'(j));
            @(negedge clk);
        end
        check("E_mid_valid", wr_if.wr_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        check("E_rst_valid", wr_if.wr_valid, 0);
        check("E_rst_busy",  busy, 0);
        check("E_rst_addr",  wr_if.wr_addr, 0);
        check("E_rst_data",  wr_if.wr_data, 0);
        check("E_rst_done",  done, 0);
        rst = 1'b0;
        @(negedge clk);
        check("E_idle_valid", wr_if.wr_valid, 0);
        capture(LANES_A, 1'b0, 4'd2, 1'b0, 11'h000);
        drain(11'h000, 1'b0, -1, "E");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pe_output_stage.md
PE_OUTPUT_STAGE -- requirements
Module: pe_output_stage

Interface
REQ-001 SHALL have parameter log_n_add, default 3, meaning log2 of lane count (8 lanes).
REQ-002 SHALL have parameter log_bit_width, default 3, meaning log2 of output byte width (8 b); input lane width is 2^(log_bit_width+1) = 16 b.
REQ-003 SHALL have parameter log_rom_size, default 11, meaning output address width.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- output_reuse  in  2^log_n_add*2^(log_bit_width+1) (128)  PE accumulator lanes; lane i = bits [16i+15:16i], signed.
- end_conv_layer  in  1  capture strobe from PE.
- relu_en  in  1  ReLU enable.
- shift_amt  in  log_bit_width+1 (4)  arithmetic right-shift amount, 0..15.
- load_out_base  in  1  load address pointer.
- out_base_addr  in  log_rom_size  value loaded into the pointer.
- wr_ready  in  1  sink accepts a byte.
- wr_valid  out  1  byte present.
- wr_addr  out  log_rom_size  write address.
- wr_data  out  2^log_bit_width (8)  signed result byte.
- busy  out  1  high in DRAIN.
- done  out  1  one-cycle pulse after the last lane is accepted.
- sat_flag  out  1  sticky: saturation occurred.
- overrun  out  1  sticky: capture strobe arrived while busy.

Function
REQ-005 SHALL implement FSM states IDLE and DRAIN.
REQ-006 In IDLE with end_conv_layer=1, SHALL register all 8 processed lanes, clear the lane index to 0, and enter DRAIN on the next edge.
REQ-007 Per-lane processing SHALL be: x = signed 16-b lane; if relu_en=1 and x<0 then x=0; y = x >>> shift_amt (sign-filling); wr byte = y clamped to [-128, 127].
REQ-008 SHALL sample relu_en and shift_amt on the capture cycle only; later changes SHALL NOT affect the buffered batch.
REQ-009 SHALL set sat_flag when any captured lane clamps; it stays set until rst or load_out_base.
REQ-010 In DRAIN, SHALL drive wr_valid=1, wr_data=byte[index] and wr_addr=pointer; busy=1.
REQ-011 On wr_valid=1 and wr_ready=1, SHALL increment index and pointer; pointer wraps modulo 2^log_rom_size (0x7FF -> 0x000).
REQ-012 While wr_valid=1 and wr_ready=0, SHALL hold wr_data and wr_addr stable.
REQ-013 On acceptance of lane 7, SHALL pulse done for exactly one cycle, drop wr_valid, and return to IDLE on the same edge.
REQ-014 Latency: first wr_valid SHALL appear 1 cycle after the capture edge; with wr_ready held high, 8 bytes SHALL transfer in 8 consecutive cycles.
REQ-015 end_conv_layer in DRAIN SHALL be ignored for data and SHALL set overrun; overrun is cleared only by rst or load_out_base.
REQ-016 load_out_base in IDLE SHALL load pointer=out_base_addr and clear sat_flag and overrun; in DRAIN it SHALL be ignored.
REQ-017 If load_out_base and end_conv_layer coincide in IDLE, the batch SHALL both load the pointer and be captured; its first byte SHALL be written to out_base_addr.
REQ-018 The pointer SHALL persist across batches, so a following batch continues at the next address.

Reset
REQ-019 On rst=1 at a clock edge, SHALL force IDLE, wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0, sat_flag=0, overrun=0, index=0 and lane buffer=0, including mid-DRAIN; no partial batch resumes.

Verification
REQ-020 Base 0x010, lanes {0x0100, 0xFF00, 0x0000, ...}, relu_en=0, shift 2, wr_ready=1 -> bytes 0x40, 0xC0, 0x00... at 0x010..0x017; done pulses on the 8th transfer; sat_flag=0.
REQ-021 Same lanes, relu_en=1 -> lane1 byte 0x00.
REQ-022 Lanes 0x7FFF and 0x8000, shift 0, relu_en=0 -> 0x7F and 0x80; sat_flag=1 until load_out_base.
REQ-023 wr_ready toggling 1,0,0,1... -> wr_data/wr_addr held while stalled; exactly 8 accepts; no duplicated or skipped addresses.
REQ-024 Base 0x7FE, one batch -> addresses 0x7FE, 0x7FF, 0x000..0x005; end_conv_layer during DRAIN -> overrun=1 and output unchanged.
REQ-025 rst asserted after the 3rd accept -> next cycle wr_valid=0, IDLE; a new capture writes from address 0x000.
